// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] NOP_OP = 4'hF;

    localparam logic [3:0] ADD    = 4'd0;
    localparam logic [3:0] SUB    = 4'd1;
    localparam logic [3:0] XOR    = 4'd2;
    localparam logic [3:0] RED    = 4'd3;
    localparam logic [3:0] SLL    = 4'd4;
    localparam logic [3:0] SRA    = 4'd5;
    localparam logic [3:0] ROR    = 4'd6;
    localparam logic [3:0] PADDSB = 4'd7;
    localparam logic [3:0] LW     = 4'd8;
    localparam logic [3:0] SW     = 4'd9;
    localparam logic [3:0] LLB    = 4'd10;
    localparam logic [3:0] LHB    = 4'd11;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; the requester that did not
// win last time takes contention. No grant while enable is low.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (&valid) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: accept -> 1 EXEC cycle -> response held
// until the owner's rsp_ready; no new accept while a response is outstanding.
module alu_share_ctrl #(
    parameter int          DW     = 16,
    parameter logic [3:0]  NOP_OP = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [7:0]      req_op,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [2:0]      rsp_flags,
    output logic [3:0]      alu_op,
    output logic [DW-1:0]   alu_in1,
    output logic [DW-1:0]   alu_in2,
    input  logic [DW-1:0]   alu_out,
    input  logic [2:0]      alu_flags
);

    import alu_share_pkg::*;

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [1:0]      grant;
    logic            arb_en;
    logic            win;
    logic [3:0]      sel_op;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;

    // rst gates the arbiter so req_ready is low for the whole reset pulse
    assign arb_en = (state == IDLE) && rst;

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign win       = grant[1];
    assign alu_in1   = a_q;
    assign alu_in2   = b_q;

    // The ALU flag register has already taken the EXEC result by the time we are in RESP
    assign rsp_flags = (state == RESP) ? alu_flags : 3'b000;

    always_comb begin
        sel_op = win ? req_op[7:4]      : req_op[3:0];
        sel_a  = win ? req_a[2*DW-1:DW] : req_a[DW-1:0];
        sel_b  = win ? req_b[2*DW-1:DW] : req_b[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            alu_op     <= NOP_OP;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        alu_op     <= sel_op;
                        owner      <= win;
                        last_grant <= win;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    alu_op    <= NOP_OP;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    alu_op    <= NOP_OP;
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU (Out + Z/N/V register).
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = 8'h00;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic [3:0]  alu_op;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] alu_out;
    logic [2:0]  alu_flags;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .alu_flags (alu_flags)
    );

    // ALU model: ADD/SUB write Z,N,V; XOR writes Z only; LLB/LHB/LW/SW and 11xx keep flags
    logic [15:0] m_out;
    logic [2:0]  m_fnext;
    logic        m_wr;

    always_comb begin
        m_out   = 16'h0;
        m_wr    = 1'b0;
        m_fnext = alu_flags;
        case (alu_op)
            4'h0: begin
                m_out   = alu_in1 + alu_in2;
                m_wr    = 1'b1;
                m_fnext = {m_out == 16'h0, m_out[15],
                           (alu_in1[15] == alu_in2[15]) && (m_out[15] != alu_in1[15])};
            end
            4'h1: begin
                m_out   = alu_in1 - alu_in2;
                m_wr    = 1'b1;
                m_fnext = {m_out == 16'h0, m_out[15],
                           (alu_in1[15] != alu_in2[15]) && (m_out[15] != alu_in1[15])};
            end
            4'h2: begin
                m_out      = alu_in1 ^ alu_in2;
                m_wr       = 1'b1;
                m_fnext[2] = (m_out == 16'h0);
            end
            4'h8, 4'h9: m_out = alu_in1 + alu_in2;
            4'hA:       m_out = {alu_in1[15:8], alu_in2[7:0]};
            4'hB:       m_out = {alu_in2[7:0], alu_in1[7:0]};
            default:    m_out = 16'h0;
        endcase
    end

    assign alu_out = m_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_flags <= 3'b000;
        else if (m_wr) alu_flags <= m_fnext;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One request from requester r; hold>0 keeps the owner's rsp_ready low for that many
    // extra cycles while the non-owner's rsp_ready is driven high.
    task automatic do_op(input string tag, input int r, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic [2:0] exp_f, input int hold);
        int t;
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        if (r == 1) begin
            req_op[7:4] = op; req_a[31:16] = a; req_b[31:16] = b;
        end else begin
            req_op[3:0] = op; req_a[15:0]  = a; req_b[15:0]  = b;
        end
        req_valid = oh;
        t = 0;
        @(negedge clk);
        while (req_ready !== oh && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rdy"}, {30'h0, req_ready}, {30'h0, oh});
        chk({tag, "_idle_op"}, {28'h0, alu_op}, 32'hF);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk({tag, "_exec_op"}, {28'h0, alu_op}, {28'h0, op});
        chk({tag, "_exec_in1"}, {16'h0, alu_in1}, {16'h0, a});
        chk({tag, "_exec_in2"}, {16'h0, alu_in2}, {16'h0, b});
        @(negedge clk);
        chk({tag, "_vld"}, {30'h0, rsp_valid}, {30'h0, oh});
        chk({tag, "_data"}, {16'h0, rsp_data}, {16'h0, exp_d});
        chk({tag, "_flags"}, {29'h0, rsp_flags}, {29'h0, exp_f});
        chk({tag, "_resp_op"}, {28'h0, alu_op}, 32'hF);
        if (hold > 0) begin
            rsp_ready = ~oh;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_hold_vld"}, {30'h0, rsp_valid}, {30'h0, oh});
                chk({tag, "_hold_data"}, {16'h0, rsp_data}, {16'h0, exp_d});
                chk({tag, "_hold_flags"}, {29'h0, rsp_flags}, {29'h0, exp_f});
                chk({tag, "_hold_op"}, {28'h0, alu_op}, 32'hF);
            end
        end
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        chk({tag, "_done_vld"}, {30'h0, rsp_valid}, 32'h0);
    endtask

    logic [1:0]  got_v [3];
    logic [15:0] got_d [3];
    int          n_rsp;

    initial begin
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {30'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
        chk("rst_rsp_flags", {29'h0, rsp_flags}, 32'h0);
        chk("rst_alu_op", {28'h0, alu_op}, 32'hF);
        req_valid = 2'b00;
        rst = 1'b1;

        do_op("add",   0, 4'h0, 16'h0003, 16'h0004, 16'h0007, 3'b000, 0);
        do_op("sub_v", 1, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 3'b001, 0);
        do_op("xor",   1, 4'h2, 16'h1234, 16'h1234, 16'h0000, 3'b101, 0);
        do_op("sub_z", 0, 4'h1, 16'h0005, 16'h0005, 16'h0000, 3'b100, 5);
        do_op("llb",   0, 4'hA, 16'hAB00, 16'h00CD, 16'hABCD, 3'b100, 0);
        do_op("op_c",  1, 4'hC, 16'h0001, 16'h0002, 16'h0000, 3'b100, 0);

        // Reset during EXEC, then both requesters contend from reset
        @(posedge clk); #1;
        req_op    = 8'h00;
        req_a     = {16'd2, 16'd1};
        req_b     = {16'd2, 16'd1};
        req_valid = 2'b01;
        @(negedge clk);
        chk("mid_rdy", {30'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_exec_op", {28'h0, alu_op}, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_vld", {30'h0, rsp_valid}, 32'h0);
        chk("mid_rst_rdy", {30'h0, req_ready}, 32'h0);
        chk("mid_rst_op", {28'h0, alu_op}, 32'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_rdy", {30'h0, req_ready}, 32'h1);
        rsp_ready = 2'b11;

        n_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            got_v[i] = 2'b00;
            got_d[i] = 16'h0;
        end
        for (int c = 0; c < 40 && n_rsp < 3; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                got_v[n_rsp] = rsp_valid;
                got_d[n_rsp] = rsp_data;
                n_rsp++;
            end
        end
        chk("cont_count", n_rsp, 3);
        chk("cont0_vld", {30'h0, got_v[0]}, 32'h1);
        chk("cont0_data", {16'h0, got_d[0]}, 32'h2);
        chk("cont1_vld", {30'h0, got_v[1]}, 32'h2);
        chk("cont1_data", {16'h0, got_d[1]}, 32'h4);
        chk("cont2_vld", {30'h0, got_v[2]}, 32'h1);
        chk("cont2_data", {16'h0, got_d[2]}, 32'h2);

        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
